sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-to-one arbiter sharing a single SRAM-like request port (req/addr_ok/data_ok handshake) between the core's instruction-fetch and data-access ports, in front of the AXI bridge. Grants one source per accepted address phase and keeps up to DEPTH accepted, unanswered transactions outstanding. Returns each in-order data_ok/rdata to the source that issued it, tracked through a source-tag FIFO. Data has fixed priority, with a starvation guard for instruction fetch.

## Interface
- DEPTH, 4: maximum outstanding accepted-but-unanswered transactions; power of two, at least 2.
- MAX_STREAK, 4: consecutive data grants allowed while inst_req is pending before inst wins once.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- inst_req / inst_wr  in  1 / 1  instruction-port request and write flag.
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr / inst_wdata  in  32 / 32  instruction-port address and write data.
- inst_uncached  in  1  uncached attribute.
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction-port address accept and data return.
- inst_rdata  out  32  instruction-port read data.
- data_req, data_wr, data_size, data_addr, data_wdata, data_uncached  in  1, 1, 2, 32, 32, 1  same meanings as the instruction-port inputs, for the data port.
- data_addr_ok, data_data_ok, data_rdata  out  1, 1, 32  same meanings as the instruction-port outputs, for the data port.
- m_req, m_wr, m_size, m_addr, m_wdata, m_uncached  out  1, 1, 2, 32, 32, 1  shared downstream request.
- m_addr_ok / m_data_ok  in  1 / 1  downstream address accept and data return.
- m_rdata  in  32  downstream read data.
- protocol_err  out  1  sticky; set when m_data_ok arrives with no outstanding tag.

## Operation
- Address phase handshake: a transfer completes when m_req & m_addr_ok. Only the granted source sees addr_ok; the other source's addr_ok is 0.
- Grant selection when unlocked:
  - data wins if data_req, unless streak == MAX_STREAK and inst_req; then inst wins.
  - otherwise inst wins if inst_req.
- Lock: if m_req is high without m_addr_ok, lock_q <= 1 and lock_src_q <= granted source. While locked, the grant is held to lock_src_q and m_* fields are muxed from that source. Lock clears on m_addr_ok.
- Upstream ports must hold req and fields until addr_ok. If a source drops its req while it is the locked source, the lock releases the same cycle: m_req = 0 for that cycle, lock_q cleared.
- m_req = (granted source req) & (count < DEPTH) & !rst.
- Streak counter, saturating at MAX_STREAK:
  - data grant accepted while inst_req high: streak + 1.
  - inst grant accepted, or inst_req low: streak = 0.
- Tag FIFO: on accept, push the source tag (0 = inst, 1 = data). On m_data_ok with count > 0, pop; route m_data_ok and m_rdata to the head source. The non-head source gets data_ok = 0 and rdata = 0.
- Simultaneous push and pop: count is unchanged and both are performed. A push is never offered when count == DEPTH, even if a pop occurs in the same cycle.
- m_data_ok with count == 0: no pop, no data_ok to either source, protocol_err <= 1. protocol_err clears only on rst.

## Timing
- Combinational paths:
  - req to m_req, 0 cycles.
  - m_addr_ok to {inst,data}_addr_ok, 0 cycles.
  - m_data_ok to {inst,data}_data_ok, 0 cycles.
- Tag push is visible to routing from the next cycle. A response in the same cycle as its own accept is illegal downstream behaviour and is treated as empty, setting protocol_err.
- Reset values: count, rd/wr pointers, lock_q, lock_src_q, streak and protocol_err are all 0.
- Output values during rst: m_req = 0, all addr_ok and data_ok = 0; other m_* fields are muxed from the inst port.
- Reset mid-transaction drops all outstanding tags. The downstream bridge is reset by the same rst.

## Structure
- Package sram_arb_pkg:
  - typedef src_e {SRC_INST = 0, SRC_DATA = 1}.
  - struct sram_req_t {wr, size, addr, wdata, uncached}.
  - localparam SIZE_BYTE/HALF/WORD.
- Sub-module arb_tag_fifo: DEPTH-entry, 1-bit synchronous FIFO with an extra count bit, full/empty, async active-high reset.

## Test plan
- inst_req only, addr 0xBFC00000, m_addr_ok on the 2nd cycle, m_data_ok 3 cycles later with rdata 0x3C080001 -> inst_addr_ok exactly once, inst_data_ok once with 0x3C080001, data_* silent.
- inst_req and data_req both high, immediate m_addr_ok -> data granted first, inst second; returns 0x11111111 then 0x22222222 reach data then inst respectively.
- data_req held continuously, inst_req held, MAX_STREAK = 4 -> 4 data accepts, then 1 inst accept, then data again; streak returns to 0.
- 4 accepts with no m_data_ok (DEPTH = 4) -> m_req = 0 on the 5th; a single m_data_ok in the cycle the 5th is pending -> m_req re-asserts the next cycle.
- m_data_ok with empty FIFO -> no data_ok, protocol_err = 1 and held; rst asserted mid-burst with 2 outstanding -> count = 0, protocol_err = 0, m_req = 0 immediately.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-source SRAM request arbiter: source tags,
// request field bundle and transfer size encodings.
package sram_arb_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncached;
  } sram_req_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_INST) ? SRC_DATA : SRC_INST;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Source-tag FIFO: remembers which port issued each accepted, still
// unanswered transaction so in-order responses can be routed back.
module arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  src_e push_src,
  input  logic pop,
  output src_e head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = src_e'(mem_q[rd_ptr_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_src;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like request port between the
// instruction and data ports, with in-order response routing by source tag.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_uncached,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_uncached,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,

  output logic        protocol_err
);

  // Handshake: an address phase completes in the cycle req & addr_ok are both
  // high; a requester holds req and its fields stable until it sees addr_ok,
  // and data_ok/rdata return one pulse per accepted transfer, in order.

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  sram_req_t   inst_f;
  sram_req_t   data_f;
  sram_req_t   sel_f;

  src_e        pick;
  src_e        sel;
  logic        sel_req;
  logic        accept;
  logic        stall;

  logic        lock_q;
  src_e        lock_src_q;
  logic [SW-1:0] streak_q;

  src_e        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        err_hit;

  assign inst_f = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                    wdata: inst_wdata, uncached: inst_uncached};
  assign data_f = '{wr: data_wr, size: data_size, addr: data_addr,
                    wdata: data_wdata, uncached: data_uncached};

  // Data has priority unless it has already won MAX_STREAK times in a row
  // over a waiting instruction fetch.
  always_comb begin
    pick = SRC_INST;
    if (data_req && !(inst_req && (streak_q == STREAK_MAX))) begin
      pick = SRC_DATA;
    end
  end

  always_comb begin
    sel = pick;
    if (rst) begin
      sel = SRC_INST;
    end else if (lock_q) begin
      sel = lock_src_q;
    end
  end

  assign sel_req = (sel == SRC_DATA) ? data_req : inst_req;
  assign sel_f   = (sel == SRC_DATA) ? data_f : inst_f;

  assign m_req      = sel_req & ~fifo_full & ~rst;
  assign m_wr       = sel_f.wr;
  assign m_size     = sel_f.size;
  assign m_addr     = sel_f.addr;
  assign m_wdata    = sel_f.wdata;
  assign m_uncached = sel_f.uncached;

  assign accept       = m_req & m_addr_ok;
  assign stall        = m_req & ~m_addr_ok;
  assign inst_addr_ok = accept & (sel == SRC_INST);
  assign data_addr_ok = accept & (sel == SRC_DATA);

  // A response only counts when a tag was already queued before this cycle.
  assign pop     = m_data_ok & ~fifo_empty & ~rst;
  assign err_hit = m_data_ok & fifo_empty;

  assign inst_data_ok = pop & (head == SRC_INST);
  assign data_data_ok = pop & (head == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? m_rdata : '0;
  assign data_rdata   = data_data_ok ? m_rdata : '0;

  arb_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_src (sel),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A stalled request pins the grant; a dropped req on the locked source
  // de-asserts m_req combinationally, so the lock falls away the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INST;
    end else begin
      lock_q <= stall;
      if (stall) begin
        lock_src_q <= sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (accept && (sel == SRC_DATA) && inst_req) begin
      if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + STREAK_ONE;
      end
    end else if ((accept && (sel == SRC_INST)) || !inst_req) begin
      streak_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if (err_hit) begin
      protocol_err <= 1'b1;
    end
  end

endmodule
